// File: rtl/beam_power_discriminator.sv
// rtl/beam_power_discriminator.sv - windowed beam power integrator with handshaked trigger record
//
// Squares eight signed 12-bit beam sums per input word, integrates WINDOW words,
// and compares the saturated window power against a threshold. A crossing produces
// one trigger record held until the consumer accepts it. The record is followed by
// HOLDOFF clocks of dead time.
//
// Ports:
//   clk           sole clock, rising edge
//   rst_n         asynchronous active-low reset (deassertion synchronised inside)
//   beam_in       eight packed signed 12-bit lanes; samples 0..3 in [47:0], 4..7 in [95:48]
//   beam_valid    beam_in carries a new word this clock
//   thresh        unsigned 24-bit power threshold, staged by thresh_wr
//   thresh_wr     one-clock strobe; staged value becomes active at next window boundary
//   trig_valid    trigger record available
//   trig_ready    consumer accepts record when trig_valid && trig_ready
//   trig_time     timestamp of the first word of the triggering window
//   trig_power    saturated integrated power of the triggering window
//   trig_lost     sticky: a crossing was discarded while a record was pending
//   scaler_count  accepted-trigger count, saturating (only with BEAM_DISC_SCALER_EN)
//
// Optional feature macro: BEAM_DISC_SCALER_EN
module beam_power_discriminator #(
    parameter int WINDOW  = 4,
    parameter int HOLDOFF = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [95:0] beam_in,
    input  logic        beam_valid,
    input  logic [23:0] thresh,
    input  logic        thresh_wr,
    output logic        trig_valid,
    input  logic        trig_ready,
    output logic [15:0] trig_time,
    output logic [23:0] trig_power,
    output logic        trig_lost
`ifdef BEAM_DISC_SCALER_EN
    ,
    output logic [15:0] scaler_count
`endif
);

    typedef enum logic [1:0] {
        ST_ARMED,
        ST_PENDING,
        ST_HOLDOFF
    } state_t;

    // Assertion is immediate; release is retimed to clk so every flop leaves
    // reset on the same edge.
    logic [1:0] rst_sync;
    logic       rst_i_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_i_n = rst_sync[1];

    // Free-running timestamp
    logic [15:0] ts;

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            ts <= '0;
        end else begin
            ts <= ts + 16'd1;
        end
    end

    // Lane unpacking
    logic signed [11:0] lane [8];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane[k]     = beam_in[47 - 12*k -: 12];
            lane[k + 4] = beam_in[95 - 12*k -: 12];
        end
    end

    // Stage 1: capture lanes and the timestamp of the capture edge
    logic               s1_valid;
    logic signed [11:0] s1_lane [8];
    logic [15:0]        s1_time;

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            s1_valid <= 1'b0;
            s1_time  <= '0;
            for (int k = 0; k < 8; k++) s1_lane[k] <= '0;
        end else begin
            s1_valid <= beam_valid;
            if (beam_valid) begin
                s1_time <= ts;
                for (int k = 0; k < 8; k++) s1_lane[k] <= lane[k];
            end
        end
    end

    // Stage 2: square each lane. The largest square is 2048^2 = 2^22, so the
    // low 23 bits of the sign-extended product are the exact unsigned result.
    logic [22:0] prod [8];
    logic [22:0] s2_sq [8];
    logic        s2_valid;
    logic [15:0] s2_time;

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            prod[k] = 23'(s1_lane[k]) * 23'(s1_lane[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            s2_valid <= 1'b0;
            s2_time  <= '0;
            for (int k = 0; k < 8; k++) s2_sq[k] <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_time  <= s1_time;
            for (int k = 0; k < 8; k++) s2_sq[k] <= prod[k];
        end
    end

    // Stage 3: sum of squares
    logic [25:0] sum_c;
    logic [25:0] s3_sum;
    logic        s3_valid;
    logic [15:0] s3_time;

    always_comb begin
        sum_c = '0;
        for (int k = 0; k < 8; k++) begin
            sum_c = sum_c + 26'(s2_sq[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            s3_valid <= 1'b0;
            s3_sum   <= '0;
            s3_time  <= '0;
        end else begin
            s3_valid <= s2_valid;
            s3_sum   <= sum_c;
            s3_time  <= s2_time;
        end
    end

    // Threshold staging
    logic [23:0] thr_staged;
    logic [23:0] thr_active;

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            thr_staged <= 24'hFFFFFF;
        end else if (thresh_wr) begin
            thr_staged <= thresh;
        end
    end

    // Window accumulator. On the last word the saturated total is compared and
    // the accumulator cleared in the same clock; the comparison result is
    // registered and acted on by the FSM one clock later.
    logic [23:0] acc;
    logic [4:0]  win_cnt;
    logic [15:0] win_time;
    logic [26:0] acc_sum;
    logic [23:0] acc_next;
    logic        win_last;
    logic        cross_q;
    logic [23:0] cross_power;
    logic [15:0] cross_time;

    assign acc_sum  = 27'(acc) + 27'(s3_sum);
    assign acc_next = (|acc_sum[26:24]) ? 24'hFFFFFF : acc_sum[23:0];
    assign win_last = (win_cnt == 5'(WINDOW - 1));

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            acc         <= '0;
            win_cnt     <= '0;
            win_time    <= '0;
            cross_q     <= 1'b0;
            cross_power <= '0;
            cross_time  <= '0;
            thr_active  <= 24'hFFFFFF;
        end else begin
            cross_q <= 1'b0;
            if (s3_valid) begin
                if (win_last) begin
                    cross_q     <= (acc_next >= thr_active);
                    cross_power <= acc_next;
                    cross_time  <= (win_cnt == 5'd0) ? s3_time : win_time;
                    acc         <= '0;
                    win_cnt     <= '0;
                    thr_active  <= thr_staged;
                end else begin
                    acc     <= acc_next;
                    win_cnt <= win_cnt + 5'd1;
                    if (win_cnt == 5'd0) begin
                        win_time <= s3_time;
                    end
                end
            end
        end
    end

    // Trigger FSM
    state_t     state;
    logic [7:0] hold_cnt;

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            state      <= ST_ARMED;
            trig_valid <= 1'b0;
            trig_time  <= '0;
            trig_power <= '0;
            trig_lost  <= 1'b0;
            hold_cnt   <= '0;
        end else begin
            case (state)
                ST_ARMED: begin
                    if (cross_q) begin
                        trig_time  <= cross_time;
                        trig_power <= cross_power;
                        trig_valid <= 1'b1;
                        state      <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (cross_q) begin
                        trig_lost <= 1'b1;
                    end
                    if (trig_ready) begin
                        trig_valid <= 1'b0;
                        hold_cnt   <= 8'(HOLDOFF);
                        state      <= ST_HOLDOFF;
                    end
                end
                ST_HOLDOFF: begin
                    // Crossings here are dropped silently; dead time is HOLDOFF clocks.
                    hold_cnt <= hold_cnt - 8'd1;
                    if (hold_cnt <= 8'd1) begin
                        state <= ST_ARMED;
                    end
                end
                default: begin
                    state <= ST_ARMED;
                end
            endcase
        end
    end

`ifdef BEAM_DISC_SCALER_EN
    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            scaler_count <= '0;
        end else if ((state == ST_PENDING) && trig_ready && (scaler_count != 16'hFFFF)) begin
            scaler_count <= scaler_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/beam_power_discriminator.md
BEAM_POWER_DISCRIMINATOR -- requirements
Module: beam_power_discriminator

Interface
REQ-001 Parameter WINDOW, default 4: input words (8 samples each) integrated per decision; legal range 1..16.
REQ-002 Parameter HOLDOFF, default 16: clocks of dead time after a trigger is accepted; legal range 1..255.
REQ-003 clk  in  1  sole clock; all logic rising-edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 beam_in  in  96  eight packed signed 12-bit beam sums: bits [47:36],[35:24],[23:12],[11:0] = samples 0..3; bits [95:84],[83:72],[71:60],[59:48] = samples 4..7.
REQ-006 beam_valid  in  1  beam_in holds a new word this clock.
REQ-007 thresh  in  24  unsigned power threshold.
REQ-008 thresh_wr  in  1  one-clock strobe; stage thresh.
REQ-009 trig_valid  out  1  trigger record available.
REQ-010 trig_ready  in  1  consumer accepts the record when trig_valid && trig_ready.
REQ-011 trig_time  out  16  timestamp of the first word of the triggering window.
REQ-012 trig_power  out  24  integrated (saturated) power of the triggering window.
REQ-013 trig_lost  out  1  sticky: a threshold crossing was discarded.

Function
REQ-014 Stage 1 SHALL register the eight lanes on beam_valid; stage 2 SHALL square each lane (signed 12x12, unsigned 23-bit result); stage 3 SHALL sum the eight squares (26-bit).
REQ-015 The window accumulator SHALL add one stage-3 sum per valid word, hold while beam_valid is low, and saturate at 24'hFFFFFF.
REQ-016 After WINDOW valid words the accumulator SHALL be compared (>=) with the active threshold and cleared in the same clock.
REQ-017 A free-running 16-bit timestamp SHALL increment every clock, wrapping 0xFFFF->0x0000; the value at capture of a window's first word SHALL be the window's time.
REQ-018 thresh_wr SHALL stage thresh; the staged value SHALL become active only at the next window boundary, never mid-window.
REQ-019 FSM states: ARMED, PENDING, HOLDOFF; reset state ARMED.
REQ-020 ARMED: crossing -> load trig_time/trig_power, assert trig_valid, go PENDING.
REQ-021 PENDING: trig_valid and record SHALL stay stable until trig_valid && trig_ready; then deassert trig_valid, load holdoff counter with HOLDOFF, go HOLDOFF.
REQ-022 HOLDOFF: counter decrements each clock; at 0 go ARMED; crossings are ignored (not lost).
REQ-023 A crossing while PENDING SHALL be discarded and set trig_lost; trig_lost clears only on reset.
REQ-024 Latency: trig_valid SHALL rise exactly 4 clocks after the edge capturing the last word of the window.
REQ-025 trig_ready asserted while not PENDING SHALL have no effect.

Reset
REQ-026 rst_n low SHALL asynchronously clear: trig_valid=0, trig_time=0, trig_power=0, trig_lost=0, accumulator, window count, pipeline, timestamp=0; FSM=ARMED.
REQ-027 Active and staged threshold SHALL reset to 24'hFFFFFF.
REQ-028 Reset mid-window or in PENDING SHALL discard all partial data and the pending record.
REQ-029 Deassertion SHALL be synchronised internally; first window starts with the first beam_valid after release.

Configuration
REQ-030 Macro BEAM_DISC_SCALER_EN: when defined, add output scaler_count [15:0] counting accepted triggers (handshake completions), saturating at 0xFFFF, reset to 0; when undefined, port and counter absent, all other behaviour identical.

Verification
REQ-031 All lanes 0, thresh=1, WINDOW=4, 8 valid words -> trig_valid never asserts, trig_lost=0.
REQ-032 All lanes 12'h800 (-2048), WINDOW=4, thresh=24'h800000 -> accumulator saturates; trig_power=24'hFFFFFF, trig_valid 4 clocks after 4th word.
REQ-033 All lanes 12'd16, WINDOW=4, thresh=8192 -> trig_power=8192, trigger fires; thresh=8193 -> no trigger.
REQ-034 Crossing with trig_ready held low 40 clocks, second crossing meanwhile -> record stable, trig_lost=1; ready high -> single handshake, then HOLDOFF=16 clocks with no trig_valid.
REQ-035 thresh_wr mid-window lowering threshold -> current window uses old threshold; next window uses new.
REQ-036 rst_n pulsed low while PENDING -> trig_valid drops immediately, timestamp 0, threshold 24'hFFFFFF; with BEAM_DISC_SCALER_EN, scaler_count=0 and counts 3 after 3 accepted triggers.
